// File: rtl/sobel_row_buffer_pkg.sv
// Shared widths and control-FSM state encoding for the Sobel 3-row window buffer.
// Optional feature macro: SOBEL_ROW_ZERO_PAD_EN (zero top/bottom border rows).
`ifndef NUM_SOBEL_ACCELERATORS
`define NUM_SOBEL_ACCELERATORS 4
`endif
`ifndef SOBEL_IDATA_WIDTH
`define SOBEL_IDATA_WIDTH ((`NUM_SOBEL_ACCELERATORS+2)*8)
`endif

package sobel_row_buffer_pkg;

  localparam int unsigned SOBEL_N  = `NUM_SOBEL_ACCELERATORS;
  localparam int unsigned IDATA_W  = `SOBEL_IDATA_WIDTH;
  localparam int unsigned ROW_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } srow_state_e;

  // Rows that must be accepted before the first window exists; with zero
  // padding the top border row stands in for one real row.
`ifdef SOBEL_ROW_ZERO_PAD_EN
  localparam logic [ROW_CNT_W-1:0] FILL_ROWS = 16'd2;
`else
  localparam logic [ROW_CNT_W-1:0] FILL_ROWS = 16'd3;
`endif

endpackage

// File: rtl/sobel_row_ctrl.sv
// Strip control FSM for sobel_row_buffer: row counting, input/output handshakes, done pulse.
// Optional feature macro: SOBEL_ROW_ZERO_PAD_EN (adds the trailing zero-row window).
module sobel_row_ctrl
  import sobel_row_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [ROW_CNT_W-1:0] num_rows_i,
  input  logic                 in_valid_i,
  input  logic                 out_ready_i,
  output logic                 in_ready_o,
  output logic                 accept_o,
  output logic                 shift_zero_o,
  output logic                 clear_rows_o,
  output logic                 out_valid_o,
  output logic                 done_o
);

  srow_state_e          state_q, state_d;
  logic [ROW_CNT_W-1:0] rows_q, rows_d;
  logic [ROW_CNT_W-1:0] cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 rows_left;
  logic                 consume;
`ifdef SOBEL_ROW_ZERO_PAD_EN
  logic                 zero_done_q, zero_done_d;
`endif

  // cnt never exceeds rows_q, so a 16-bit counter cannot wrap even at 65535.
  assign rows_left = (cnt_q < rows_q);
  assign consume   = valid_q && out_ready_i;

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    in_ready_o   = 1'b0;
    accept_o     = 1'b0;
    shift_zero_o = 1'b0;
    clear_rows_o = 1'b0;
    done_o       = 1'b0;
`ifdef SOBEL_ROW_ZERO_PAD_EN
    zero_done_d  = zero_done_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rows_d  = num_rows_i;
          cnt_d   = '0;
          valid_d = 1'b0;
`ifdef SOBEL_ROW_ZERO_PAD_EN
          clear_rows_o = 1'b1;
          zero_done_d  = 1'b0;
`endif
          state_d = (num_rows_i < FILL_ROWS) ? ST_DONE : ST_FILL;
        end
      end

      ST_FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept_o = 1'b1;
          cnt_d    = cnt_q + 16'd1;
          if (cnt_d == FILL_ROWS) begin
            valid_d = 1'b1;
            state_d = ST_STREAM;
          end
        end
      end

      ST_STREAM: begin
        in_ready_o = (!valid_q || out_ready_i) && rows_left;
        if (in_ready_o && in_valid_i) begin
          // Accept with or without a concurrent consume: window slides, no bubble.
          accept_o = 1'b1;
          cnt_d    = cnt_q + 16'd1;
          valid_d  = 1'b1;
        end else if (!rows_left && (consume || !valid_q)) begin
`ifdef SOBEL_ROW_ZERO_PAD_EN
          if (!zero_done_q) begin
            shift_zero_o = 1'b1;
            zero_done_d  = 1'b1;
            valid_d      = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end
`else
          valid_d = 1'b0;
          state_d = ST_DONE;
`endif
        end else if (consume) begin
          valid_d = 1'b0;
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rows_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

`ifdef SOBEL_ROW_ZERO_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_done_q <= 1'b0;
    else        zero_done_q <= zero_done_d;
  end
`endif

  assign out_valid_o = valid_q;

endmodule

// File: rtl/sobel_row_buffer.sv
// Three-row sliding window over a column strip; window registered 1 cycle after its last chunk.
// Optional feature macro: SOBEL_ROW_ZERO_PAD_EN (zero border rows above and below the strip).
module sobel_row_buffer
  import sobel_row_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ROW_CNT_W-1:0] num_rows,
  input  logic                 mem2srow_valid,
  input  logic [IDATA_W-1:0]   mem2srow_data,
  output logic                 srow2mem_ready,
  output logic [IDATA_W-1:0]   srow2sacc_row1_data,
  output logic [IDATA_W-1:0]   srow2sacc_row2_data,
  output logic [IDATA_W-1:0]   srow2sacc_row3_data,
  output logic                 srow2sacc_valid,
  input  logic                 swt2srow_ready,
  output logic                 srow_done
);

  logic               accept;
  logic               shift_zero;
  logic               clear_rows;
  logic [IDATA_W-1:0] row1_q, row1_d;
  logic [IDATA_W-1:0] row2_q, row2_d;
  logic [IDATA_W-1:0] row3_q, row3_d;

  sobel_row_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .num_rows_i   (num_rows),
    .in_valid_i   (mem2srow_valid),
    .out_ready_i  (swt2srow_ready),
    .in_ready_o   (srow2mem_ready),
    .accept_o     (accept),
    .shift_zero_o (shift_zero),
    .clear_rows_o (clear_rows),
    .out_valid_o  (srow2sacc_valid),
    .done_o       (srow_done)
  );

  // Rows only move on accept or the internal zero shift, so the window is
  // stable for as long as the consumer stalls.
  always_comb begin
    row1_d = row1_q;
    row2_d = row2_q;
    row3_d = row3_q;
    if (clear_rows) begin
      row1_d = '0;
      row2_d = '0;
      row3_d = '0;
    end else if (accept) begin
      row1_d = row2_q;
      row2_d = row3_q;
      row3_d = mem2srow_data;
    end else if (shift_zero) begin
      row1_d = row2_q;
      row2_d = row3_q;
      row3_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row1_q <= '0;
      row2_q <= '0;
      row3_q <= '0;
    end else begin
      row1_q <= row1_d;
      row2_q <= row2_d;
      row3_q <= row3_d;
    end
  end

  assign srow2sacc_row1_data = row1_q;
  assign srow2sacc_row2_data = row2_q;
  assign srow2sacc_row3_data = row3_q;

endmodule

// File: tb/tb_sobel_row_buffer.sv
// Randomized self-checking bench for sobel_row_buffer against a row-list window model.
module tb_sobel_row_buffer;
  localparam int W = sobel_row_buffer_pkg::IDATA_W;
`ifdef SOBEL_ROW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  num_rows = '0;
  logic         mem2srow_valid = 1'b0;
  logic [W-1:0] mem2srow_data = '0;
  logic         srow2mem_ready;
  logic [W-1:0] r1, r2, r3;
  logic         srow2sacc_valid;
  logic         swt2srow_ready = 1'b0;
  logic         srow_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sobel_row_buffer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .num_rows            (num_rows),
    .mem2srow_valid      (mem2srow_valid),
    .mem2srow_data       (mem2srow_data),
    .srow2mem_ready      (srow2mem_ready),
    .srow2sacc_row1_data (r1),
    .srow2sacc_row2_data (r2),
    .srow2sacc_row3_data (r3),
    .srow2sacc_valid     (srow2sacc_valid),
    .swt2srow_ready      (swt2srow_ready),
    .srow_done           (srow_done)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fill_bytes(input int v);
    logic [W-1:0] r;
    for (int b = 0; b < W/8; b++) r[b*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int b = 0; b < W/8; b++) r[b*8 +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // kind: 0 random rows, 1 row k = all bytes k+1, 2 row k = all bytes k+7.
  task automatic run_strip(input int n, input int unsigned v_pct, input int unsigned r_pct,
                           input int hold_first, input bit restart, input int kind, input string nm);
    logic [W-1:0]   chunks[$];
    logic [W-1:0]   ext[$];
    logic [3*W-1:0] expw[$];
    logic [3*W-1:0] held_w;
    int  idx = 0, nw = 0, exp_acc, budget, hold_left, last_cons = -10, done_cyc = -1;
    bit  held = 1'b0, got_done = 1'b0, restarted = 1'b0;
    bit  full_rate;

    full_rate = (v_pct == 100) && (r_pct == 100) && (hold_first == 0);
    for (int i = 0; i < n; i++) begin
      case (kind)
        1:       chunks.push_back(fill_bytes(i + 1));
        2:       chunks.push_back(fill_bytes(i + 7));
        default: chunks.push_back(rand_row());
      endcase
    end
    // Reference: window i is rows (i, i+1, i+2) of the (optionally zero-bordered) strip.
    if (PAD) begin
      if (n >= 2) begin
        ext.push_back('0);
        foreach (chunks[i]) ext.push_back(chunks[i]);
        ext.push_back('0);
      end
    end else if (n >= 3) begin
      foreach (chunks[i]) ext.push_back(chunks[i]);
    end
    for (int i = 0; i + 2 < ext.size(); i++) expw.push_back({ext[i], ext[i+1], ext[i+2]});
    exp_acc = (ext.size() > 0) ? n : 0;

    start = 1'b1;
    num_rows = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    budget = 40 * n + 100;
    hold_left = hold_first;

    for (int c = 0; c < budget && !got_done; c++) begin
      start = 1'b0;
      if (restart && srow2sacc_valid && !restarted) begin
        start = 1'b1;
        num_rows = 16'd2;
        restarted = 1'b1;
      end
      mem2srow_valid = (idx < n) && ($urandom_range(0, 99) < v_pct);
      mem2srow_data  = (idx < n) ? chunks[idx] : rand_row();
      if (srow2sacc_valid && nw == 0 && hold_left > 0) begin
        swt2srow_ready = 1'b0;
        hold_left--;
      end else begin
        swt2srow_ready = ($urandom_range(0, 99) < r_pct);
      end
      #1;
      if (held) begin
        check({nm, " hold valid"}, 192'(srow2sacc_valid), 192'(1));
        check({nm, " hold window"}, 192'({r1, r2, r3}), 192'(held_w));
      end
      if (srow2sacc_valid && !swt2srow_ready)
        check({nm, " stall ready"}, 192'(srow2mem_ready), 192'(0));
      if (idx >= exp_acc)
        check({nm, " ready after last"}, 192'(srow2mem_ready), 192'(0));
      held   = srow2sacc_valid && !swt2srow_ready;
      held_w = {r1, r2, r3};
      if (srow2mem_ready && mem2srow_valid) idx++;
      if (srow2sacc_valid && swt2srow_ready) begin
        if (nw < expw.size()) check({nm, " window"}, 192'({r1, r2, r3}), 192'(expw[nw]));
        else                  check({nm, " extra window"}, 192'(nw + 1), 192'(expw.size()));
        if (full_rate && nw > 0) check({nm, " window gap"}, 192'(c - last_cons), 192'(1));
        last_cons = c;
        nw++;
      end
      if (srow_done) begin
        got_done = 1'b1;
        done_cyc = c;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    swt2srow_ready = 1'b0;

    check({nm, " done seen"}, 192'(got_done), 192'(1));
    check({nm, " window count"}, 192'(nw), 192'(expw.size()));
    check({nm, " accepted"}, 192'(idx), 192'(exp_acc));
    if (full_rate && nw > 0 && got_done)
      check({nm, " done latency"}, 192'(done_cyc - last_cons), 192'(1));

    // One cycle after the pulse: back in IDLE, so valid input is not taken.
    mem2srow_valid = 1'b1;
    #1;
    check({nm, " done pulse width"}, 192'(srow_done), 192'(0));
    check({nm, " idle ready"}, 192'(srow2mem_ready), 192'(0));
    check({nm, " idle valid"}, 192'(srow2sacc_valid), 192'(0));
    mem2srow_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_stream();
    int c = 0;
    start = 1'b1;
    num_rows = 16'd6;
    @(posedge clk); #1;
    start = 1'b0;
    mem2srow_valid = 1'b1;
    swt2srow_ready = 1'b0;
    while (!srow2sacc_valid && c < 20) begin
      mem2srow_data = rand_row();
      @(posedge clk); #1;
      c++;
    end
    check("rst reached stream", 192'(srow2sacc_valid), 192'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst valid", 192'(srow2sacc_valid), 192'(0));
    check("rst ready", 192'(srow2mem_ready), 192'(0));
    check("rst done", 192'(srow_done), 192'(0));
    check("rst rows", 192'({r1, r2, r3}), 192'(0));
    @(posedge clk); #1;
    check("rst held valid", 192'(srow2sacc_valid), 192'(0));
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post rst waits start", 192'(srow2mem_ready), 192'(0));
    end
    mem2srow_valid = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #4;
    check("reset ready", 192'(srow2mem_ready), 192'(0));
    check("reset valid", 192'(srow2sacc_valid), 192'(0));
    check("reset done", 192'(srow_done), 192'(0));
    check("reset rows", 192'({r1, r2, r3}), 192'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_strip(5, 100, 100, 0, 1'b0, 1, "ramp5");
    run_strip(4, 100, 100, 4, 1'b0, 0, "stall4");
    run_strip(2, 100, 100, 0, 1'b0, 0, "rows2");
    run_strip(0, 100, 100, 0, 1'b0, 0, "rows0");
    reset_mid_stream();
    run_strip(3, 100, 100, 0, 1'b0, 0, "after rst");
`ifdef SOBEL_ROW_ZERO_PAD_EN
    run_strip(3, 100, 100, 0, 1'b0, 2, "pad789");
`endif
    run_strip(6, 100, 100, 0, 1'b1, 0, "start in stream");
    for (int t = 0; t < 12; t++)
      run_strip(int'($urandom_range(0, 12)), $urandom_range(30, 100), $urandom_range(30, 100),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_row_buffer.md
SOBEL_ROW_BUFFER -- requirements
Module: sobel_row_buffer

Interface
REQ-001 SHALL use parameters from common_defines.v: `NUM_SOBEL_ACCELERATORS (N), `SOBEL_IDATA_WIDTH ((N+2)*8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, one-cycle pulse that begins a column strip.
REQ-005 SHALL have port num_rows, input, 16, image height in rows; sampled on accepted start.
REQ-006 SHALL have port mem2srow_valid, input, 1, input row chunk valid.
REQ-007 SHALL have port mem2srow_data, input, `SOBEL_IDATA_WIDTH, one row chunk of N+2 pixels.
REQ-008 SHALL have port srow2mem_ready, output, 1, input chunk accepted when valid&&ready.
REQ-009 SHALL have ports srow2sacc_row1_data, srow2sacc_row2_data and srow2sacc_row3_data, each output, `SOBEL_IDATA_WIDTH; they carry the top, middle and bottom window rows.
REQ-010 SHALL have port srow2sacc_valid, output, 1, window valid.
REQ-011 SHALL have port swt2srow_ready, input, 1, downstream writer consumes the window when valid&&ready.
REQ-012 SHALL have port srow_done, output, 1, one-cycle pulse at strip end.

Function
REQ-013 SHALL implement FSM states IDLE, FILL, STREAM, DONE.
REQ-014 IDLE: on start, SHALL latch num_rows, clear the row counter and go to FILL; start SHALL be ignored in every other state.
REQ-015 FILL and STREAM: each accepted chunk SHALL shift row1<=row2, row2<=row3, row3<=chunk and increment the accepted-row counter.
REQ-016 srow2mem_ready SHALL be 1 in FILL, and in STREAM only when (!srow2sacc_valid || swt2srow_ready) and rows remain; it SHALL be 0 otherwise.
REQ-017 FILL SHALL go to STREAM and assert srow2sacc_valid the cycle after the 3rd accepted chunk (latency 1 cycle).
REQ-018 srow2sacc_valid and all row outputs SHALL hold stable until the consume handshake.
REQ-019 A simultaneous consume and accept SHALL shift the window and keep valid asserted, with no bubble.
REQ-020 A consume with no accept SHALL deassert valid the next cycle.
REQ-021 After num_rows chunks have been accepted and the last window consumed, the FSM SHALL go to DONE; DONE SHALL pulse srow_done for 1 cycle and then return to IDLE.
REQ-022 A strip SHALL produce num_rows-2 windows; num_rows<3 SHALL accept no chunks and go directly to DONE.
REQ-023 Valid input presented while not ready SHALL be ignored, and no data SHALL be dropped.
REQ-024 Counters SHALL be 16-bit unsigned and SHALL NOT wrap within a strip (num_rows=65535 is legal).

Reset
REQ-025 While rst_n=0, the block SHALL be in IDLE, all row registers and counters SHALL be 0, and srow2sacc_valid, srow2mem_ready and srow_done SHALL all be 0.
REQ-026 Reset asserted mid-strip SHALL abort immediately; after release the block SHALL wait for a new start.

Configuration
REQ-027 With macro SOBEL_ROW_ZERO_PAD_EN defined, row registers SHALL clear on start, and FILL SHALL need only 2 chunks, so the first window is (0, r0, r1).
REQ-028 With SOBEL_ROW_ZERO_PAD_EN defined, after the last chunk the FSM SHALL internally shift in one zero row and emit a window (r[n-2], r[n-1], 0). This gives num_rows windows, and num_rows<2 SHALL go directly to DONE.
REQ-029 Without SOBEL_ROW_ZERO_PAD_EN, behaviour SHALL be exactly REQ-013..024.

Structure
REQ-030 FSM state encodings and the width macros SHALL live in common_defines.v.
REQ-031 The FSM and counters MAY be a sub-module sobel_row_ctrl; the row registers SHALL stay in the top level.

Verification
REQ-032 The bench SHALL cover: num_rows=5, chunks with all bytes = k (k=1..5), ready held 1 -> 3 windows (1,2,3), (2,3,4), (3,4,5) on consecutive cycles, then srow_done 1 cycle later.
REQ-033 The bench SHALL cover: num_rows=4 with swt2srow_ready low for 4 cycles on the first window -> window held stable, srow2mem_ready=0, no chunk lost, 2 windows total.
REQ-034 The bench SHALL cover: num_rows=2 and num_rows=0 -> no chunks accepted, srow_done pulses, back in IDLE.
REQ-035 The bench SHALL cover: rst_n low during STREAM of num_rows=6 -> outputs 0 asynchronously; a new start with num_rows=3 then yields exactly 1 window.
REQ-036 The bench SHALL cover: SOBEL_ROW_ZERO_PAD_EN defined, num_rows=3 (values 7, 8, 9) -> windows (0,7,8), (7,8,9), (8,9,0).
REQ-037 The bench SHALL cover: start pulsed during STREAM -> ignored; window count unchanged.
